// File: rtl/axi2apb_cmd_pkg.sv
// Shared definitions for the AXI-to-APB command stage: command entry layout and
// the rule that flags AXI requests the single-beat APB path cannot serve.
package axi2apb_cmd_pkg;

   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Entry layout, MSB first: {read, err, id, addr}
   function automatic int cmd_w(input int id_bits, input int addr_bits);
      return 2 + id_bits + addr_bits;
   endfunction

   function automatic logic cmd_err_f(input logic [3:0] len,
                                      input logic [1:0] size,
                                      input logic [1:0] addr_lo);
      return (len != 4'd0) | (size != SIZE_WORD) | (addr_lo != 2'd0);
   endfunction

endpackage

// File: rtl/axi2apb_cmd_fifo.sv
// In-order command FIFO: a push is visible at the head after its edge and a pop exposes the next entry after its edge.
// A push while full and a pop while empty are dropped; full/empty/count come from registers only.
module axi2apb_cmd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/axi2apb_cmd.sv
// AXI AW/AR round-robin intake feeding the APB command FIFO; a push at edge N shows at the head after edge N.
// Ready depends on registered full only, so a pop never reopens ready in the same cycle.
module axi2apb_cmd
   import axi2apb_cmd_pkg::*;
#(
   parameter int ADDR_BITS = 32,
   parameter int ID_BITS   = 4,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ID_BITS-1:0]   AWID,
   input  logic [ADDR_BITS-1:0] AWADDR,
   input  logic [3:0]           AWLEN,
   input  logic [1:0]           AWSIZE,
   input  logic                 AWVALID,
   output logic                 AWREADY,
   input  logic [ID_BITS-1:0]   ARID,
   input  logic [ADDR_BITS-1:0] ARADDR,
   input  logic [3:0]           ARLEN,
   input  logic [1:0]           ARSIZE,
   input  logic                 ARVALID,
   output logic                 ARREADY,
   input  logic                 finish_wr,
   input  logic                 finish_rd,
   output logic                 cmd_empty,
   output logic                 cmd_read,
   output logic [ADDR_BITS-1:0] cmd_addr,
   output logic [ID_BITS-1:0]   cmd_id,
   output logic                 cmd_err
);

   localparam int CMD_W = cmd_w(ID_BITS, ADDR_BITS);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             full, empty;
   logic [CNT_W-1:0] count;
   logic             last_read_q, last_read_d;
   logic             aw_push, ar_push, push, pop;
   logic             push_err;
   logic [CMD_W-1:0] push_dat, head_dat;

   // On contention the channel not served last wins; last_read resets to 1 so writes win first.
   always_comb begin
      AWREADY     = reset & ~full & (~ARVALID | last_read_q);
      ARREADY     = reset & ~full & (~AWVALID | ~last_read_q);
      aw_push     = AWVALID & AWREADY;
      ar_push     = ARVALID & ARREADY;
      push        = aw_push | ar_push;
      pop         = finish_wr | finish_rd;
      last_read_d = push ? ar_push : last_read_q;
      if (ar_push) begin
         push_err = cmd_err_f(ARLEN, ARSIZE, ARADDR[1:0]);
         push_dat = {1'b1, push_err, ARID, ARADDR};
      end else begin
         push_err = cmd_err_f(AWLEN, AWSIZE, AWADDR[1:0]);
         push_dat = {1'b0, push_err, AWID, AWADDR};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_read_q <= 1'b1;
      end else begin
         last_read_q <= last_read_d;
      end
   end

   axi2apb_cmd_fifo #(
      .W     (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   assign cmd_empty = empty;
   assign cmd_read  = head_dat[CMD_W-1];
   assign cmd_err   = head_dat[CMD_W-2];
   assign cmd_id    = head_dat[ADDR_BITS +: ID_BITS];
   assign cmd_addr  = head_dat[ADDR_BITS-1:0];

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset) begin
         assert (!(pop && cmd_empty))
            else $warning("finish while cmd_empty, ignored");
         assert (!(finish_wr && finish_rd))
            else $error("finish_wr and finish_rd in the same cycle");
         assert (!(finish_wr && !cmd_empty && cmd_read))
            else $error("finish_wr while head is a read");
         assert (!(finish_rd && !cmd_empty && !cmd_read))
            else $error("finish_rd while head is a write");
         assert (int'(count) <= DEPTH)
            else $error("command count above DEPTH");
      end
   end
`endif

endmodule

// File: tb/tb_axi2apb_cmd.sv
// Directed bench for axi2apb_cmd with a scoreboard of expected head commands.
module tb_axi2apb_cmd;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  AWID = '0, ARID = '0;
   logic [31:0] AWADDR = '0, ARADDR = '0;
   logic [3:0]  AWLEN = '0, ARLEN = '0;
   logic [1:0]  AWSIZE = 2'd2, ARSIZE = 2'd2;
   logic        AWVALID = 1'b0, ARVALID = 1'b0;
   logic        AWREADY, ARREADY;
   logic        finish_wr = 1'b0, finish_rd = 1'b0;
   logic        cmd_empty, cmd_read, cmd_err;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_id;

   axi2apb_cmd #(.ADDR_BITS(32), .ID_BITS(4), .DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .finish_wr(finish_wr), .finish_rd(finish_rd),
      .cmd_empty(cmd_empty), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
      .cmd_id(cmd_id), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        err;
      logic [3:0]  id;
      logic [31:0] addr;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic err_m(input logic [3:0] len, input logic [1:0] size, input logic [31:0] addr);
      return (len != 4'd0) || (size != 2'd2) || (addr[1:0] != 2'b00);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: scoreboard empty, got cmd_empty=%0b expected an entry", tag, cmd_empty);
      end else begin
         e = q[0];
         chk({tag, "_empty"}, cmd_empty, 0);
         chk({tag, "_read"},  cmd_read,  e.rd);
         chk({tag, "_err"},   cmd_err,   e.err);
         chk({tag, "_id"},    cmd_id,    e.id);
         chk({tag, "_addr"},  cmd_addr,  e.addr);
      end
   endtask

   task automatic pop_head(input string tag);
      chk_head(tag);
      if (q.size() != 0) begin
         finish_rd = q[0].rd;
         finish_wr = !q[0].rd;
         cyc();
         finish_rd = 1'b0;
         finish_wr = 1'b0;
         void'(q.pop_front());
      end
   endtask

   task automatic push_aw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] size);
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
      #1;
      chk("aw_ready", AWREADY, 1);
      cyc();
      AWVALID = 1'b0;
      q.push_back('{1'b0, err_m(len, size, addr), id, addr});
   endtask

   task automatic push_ar(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] size);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
      #1;
      chk("ar_ready", ARREADY, 1);
      cyc();
      ARVALID = 1'b0;
      q.push_back('{1'b1, err_m(len, size, addr), id, addr});
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      q.delete();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt_m, nw, nr, npop;
      logic lr_m, exp_aw, exp_ar, popped;
      logic [3:0]  lens [4];
      logic [1:0]  sizes[4];
      logic [31:0] addrs[4];
      logic        errs [4];

      // Reset state
      #2;
      chk("rst_awready", AWREADY, 0);
      chk("rst_arready", ARREADY, 0);
      chk("rst_empty", cmd_empty, 1);
      cyc();
      reset = 1'b1;
      #1;
      chk("idle_empty", cmd_empty, 1);
      chk("idle_read", cmd_read, 0);
      chk("idle_addr", cmd_addr, 0);
      chk("idle_id", cmd_id, 0);
      chk("idle_err", cmd_err, 0);
      chk("idle_awready", AWREADY, 1);
      chk("idle_arready", ARREADY, 1);

      // Single write
      push_aw(4'd3, 32'h1000, 4'd0, 2'd2);
      pop_head("wr1");
      chk("wr1_done_empty", cmd_empty, 1);

      // Contention from reset: expected grant order W0,R0,W1,R1,...
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q.push_back('{1'b0, 1'b0, 4'(i), 32'h2000 + 32'(i * 4)});
         q.push_back('{1'b1, 1'b0, 4'(8 + i), 32'h3000 + 32'(i * 4)});
      end
      cnt_m = 0; lr_m = 1'b1; nw = 0; nr = 0; npop = 0;
      for (int c = 0; c < 100 && npop < 8; c++) begin
         AWVALID = (nw < 4);
         ARVALID = (nr < 4);
         AWADDR  = 32'h2000 + 32'(nw * 4); AWID = 4'(nw); AWLEN = 0; AWSIZE = 2;
         ARADDR  = 32'h3000 + 32'(nr * 4); ARID = 4'(8 + nr); ARLEN = 0; ARSIZE = 2;
         popped  = 1'b0;
         if (cnt_m == 2 || (nw == 4 && nr == 4 && cnt_m > 0)) begin
            chk_head($sformatf("arb%0d", npop));
            finish_rd = q[0].rd;
            finish_wr = !q[0].rd;
            popped    = 1'b1;
         end
         #1;
         exp_aw = (cnt_m < 2) && AWVALID && (!ARVALID || lr_m);
         exp_ar = (cnt_m < 2) && ARVALID && (!AWVALID || !lr_m);
         chk($sformatf("arb_awready_c%0d", c), AWREADY, (cnt_m < 2) && (!ARVALID || lr_m));
         chk($sformatf("arb_arready_c%0d", c), ARREADY, (cnt_m < 2) && (!AWVALID || !lr_m));
         cyc();
         finish_rd = 1'b0;
         finish_wr = 1'b0;
         if (exp_aw) begin nw++; lr_m = 1'b0; cnt_m++; end
         else if (exp_ar) begin nr++; lr_m = 1'b1; cnt_m++; end
         if (popped) begin cnt_m--; npop++; void'(q.pop_front()); end
      end
      AWVALID = 1'b0;
      ARVALID = 1'b0;
      if (npop < 8) begin
         tests++;
         fails++;
         $error("FAIL arb_budget: popped %0d expected 8", npop);
      end
      chk("arb_done_empty", cmd_empty, 1);

      // Fill with reads, then pop while presenting a new AR
      push_ar(4'd1, 32'h4000, 4'd0, 2'd2);
      push_ar(4'd2, 32'h4004, 4'd0, 2'd2);
      ARID = 4'd3; ARADDR = 32'h4008; ARLEN = 0; ARSIZE = 2; ARVALID = 1'b1;
      chk_head("full0");
      finish_rd = 1'b1;
      #1;
      chk("full_pop_arready", ARREADY, 0);
      cyc();
      finish_rd = 1'b0;
      void'(q.pop_front());
      chk("after_pop_arready", ARREADY, 1);
      chk_head("full1");
      cyc();
      ARVALID = 1'b0;
      q.push_back('{1'b1, 1'b0, 4'd3, 32'h4008});
      chk("refull_arready", ARREADY, 0);
      chk("refull_awready", AWREADY, 0);
      pop_head("full1b");
      pop_head("full2");
      chk("full_done_empty", cmd_empty, 1);

      // Error qualification
      lens  = '{4'd1, 4'd0, 4'd0, 4'd0};
      sizes = '{2'd2, 2'd1, 2'd2, 2'd2};
      addrs = '{32'h1000, 32'h1000, 32'h1002, 32'h1004};
      errs  = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         push_ar(4'(i), addrs[i], lens[i], sizes[i]);
         chk($sformatf("err_tbl%0d", i), cmd_err, errs[i]);
         pop_head($sformatf("err%0d", i));
      end
      push_aw(4'd7, 32'h1008, 4'd3, 2'd2);
      chk("err_aw_len", cmd_err, 1);
      pop_head("err_aw");

      // Spurious finish_rd right after reset
      do_reset();
      finish_rd = 1'b1;
      cyc();
      finish_rd = 1'b0;
      chk("spur_empty", cmd_empty, 1);
      chk("spur_addr", cmd_addr, 0);
      chk("spur_awready", AWREADY, 1);
      push_aw(4'd5, 32'h5000, 4'd0, 2'd2);
      chk_head("spur_head");
      push_ar(4'd6, 32'h6000, 4'd0, 2'd2);
      pop_head("spur_p0");
      pop_head("spur_p1");
      chk("spur_done_empty", cmd_empty, 1);

      // Reset mid-stream with two entries queued
      push_aw(4'd1, 32'h7000, 4'd0, 2'd2);
      push_aw(4'd2, 32'h7004, 4'd0, 2'd2);
      chk("mid_full_awready", AWREADY, 0);
      chk("mid_not_empty", cmd_empty, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_empty", cmd_empty, 1);
      chk("mid_rst_addr", cmd_addr, 0);
      chk("mid_rst_awready", AWREADY, 0);
      q.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rel_awready", AWREADY, 1);
      chk("mid_rel_empty", cmd_empty, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
